// File: rtl/multi_event_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_event_counter_pkg
// Description : Register offsets, CTRL bit indices and a write-strobe helper
//               shared by the multi-channel event counter.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_event_counter_pkg;

    typedef logic [31:0] word_t;

    // Byte offsets of the control/status registers
    localparam logic [7:0] C_OFF_CTRL      = 8'h00;
    localparam logic [7:0] C_OFF_OVF       = 8'h04;
    localparam logic [7:0] C_OFF_IRQ_EN    = 8'h08;
    localparam logic [7:0] C_OFF_INFO      = 8'h0C;
    localparam logic [7:0] C_OFF_CNT_BASE  = 8'h40;
    localparam logic [7:0] C_OFF_SNAP_BASE = 8'h80;

    // CTRL bit positions
    localparam int C_CTRL_RUN   = 0;
    localparam int C_CTRL_EDGE  = 1;
    localparam int C_CTRL_SAT   = 2;
    localparam int C_CTRL_CLEAR = 3;
    localparam int C_CTRL_SNAP  = 4;
    localparam int C_CTRL_W     = 5;

    // Expand a 4-bit byte strobe into a 32-bit bit mask
    function automatic word_t strb_to_mask(input logic [3:0] strb);
        word_t m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_event_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_event_counter_if
// Description : AXI4-Lite control bus (32-bit data) with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_event_counter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axi4l_sif.sv
`default_nettype none
// ============================================================================
// Module      : axi4l_sif
// Description : AXI4-Lite slave front-end. Turns bus transactions into a
//               single-cycle register write strobe and a combinational read
//               lookup; one outstanding write and one outstanding read.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4l_sif #(
    parameter int ADDR_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  srstn,
    multi_event_counter_if.slave       s_axi,
    output logic [ADDR_WIDTH-1:0]      acc__waddr,
    output logic [31:0]                acc__wdata,
    output logic [3:0]                 acc__wstrb,
    output logic                       acc__wvalid,
    input  wire logic                  acc__wready,
    output logic [ADDR_WIDTH-1:0]      acc__raddr,
    input  wire logic                  acc__rready,
    input  wire logic [31:0]           acc__rdata
);
    logic        bvalid_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        w_wr_fire;
    logic        w_rd_fire;

    // Address and data must arrive together; no new write while B is pending
    assign w_wr_fire     = s_axi.awvalid & s_axi.wvalid & ~bvalid_q & acc__wready;
    assign w_rd_fire     = s_axi.arvalid & s_axi.arready;

    assign s_axi.awready = w_wr_fire;
    assign s_axi.wready  = w_wr_fire;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = ~rvalid_q & acc__rready;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;

    assign acc__waddr    = s_axi.awaddr;
    assign acc__wdata    = s_axi.wdata;
    assign acc__wstrb    = s_axi.wstrb;
    assign acc__wvalid   = w_wr_fire;
    assign acc__raddr    = s_axi.araddr;

    // Write response: raised after an accepted write, dropped on bready
    always_ff @(posedge clk) begin
        if (!srstn) begin
            bvalid_q <= 1'b0;
        end else if (w_wr_fire) begin
            bvalid_q <= 1'b1;
        end else if (s_axi.bready) begin
            bvalid_q <= 1'b0;
        end
    end

    // Read response: capture register data at address acceptance
    always_ff @(posedge clk) begin
        if (!srstn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (w_rd_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= acc__rdata;
        end else if (s_axi.rready) begin
            rvalid_q <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/event_counter_channel.sv
`default_nettype none
// ============================================================================
// Module      : event_counter_channel
// Description : One probe channel: edge history, live counter, snapshot
//               register and an overflow pulse for the shared OVF register.
// Revision    : 1.0 - initial release
// ============================================================================
module event_counter_channel #(
    parameter int COUNTER_WIDTH = 32
) (
    input  wire logic                     clk,
    input  wire logic                     srstn,
    input  wire logic                     enable_i,
    input  wire logic                     probe_i,
    input  wire logic                     inc_en_i,
    input  wire logic                     edge_mode_i,
    input  wire logic                     saturate_i,
    input  wire logic                     clear_i,
    input  wire logic                     snap_i,
    output logic [COUNTER_WIDTH-1:0]      cnt_o,
    output logic [COUNTER_WIDTH-1:0]      snap_o,
    output logic                          ovf_o
);
    logic                     prev_q;
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [COUNTER_WIDTH-1:0] cnt_d;
    logic [COUNTER_WIDTH-1:0] snap_q;
    logic                     w_event;
    logic                     w_inc;
    logic                     w_all_ones;

    // Next count: clear beats increment, saturate pins at all-ones
    always_comb begin
        w_event    = edge_mode_i ? (probe_i & ~prev_q) : probe_i;
        w_inc      = inc_en_i & w_event & ~clear_i;
        w_all_ones = &cnt_q;
        cnt_d      = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (w_inc && !(w_all_ones && saturate_i)) begin
            cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
    end

    assign ovf_o  = w_inc & w_all_ones;
    assign cnt_o  = cnt_q;
    assign snap_o = snap_q;

    // Channel state; dropping enable wipes it like a reset
    always_ff @(posedge clk) begin
        if (!srstn || !enable_i) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            prev_q <= probe_i;
            cnt_q  <= cnt_d;
            if (snap_i) begin
                snap_q <= cnt_q;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/multi_event_counter.sv
`default_nettype none
// ============================================================================
// Module      : multi_event_counter
// Description : Multi-channel event counter with AXI4-Lite register access,
//               wrap/saturate, overflow flags, atomic snapshot and irq.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_event_counter
    import multi_event_counter_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int NUM_CHANNELS   = 4,
    parameter int COUNTER_WIDTH  = 32
) (
    input  wire logic                    clk,
    input  wire logic                    srstn,
    input  wire logic                    enable,
    multi_event_counter_if.slave         s_axi_ctl,
    input  wire logic [NUM_CHANNELS-1:0] probe,
    output logic                         irq
);
    localparam logic [5:0] C_IDX_CTRL   = C_OFF_CTRL[7:2];
    localparam logic [5:0] C_IDX_OVF    = C_OFF_OVF[7:2];
    localparam logic [5:0] C_IDX_IRQ_EN = C_OFF_IRQ_EN[7:2];
    localparam logic [5:0] C_IDX_INFO   = C_OFF_INFO[7:2];
    localparam logic [5:0] C_IDX_CNT    = C_OFF_CNT_BASE[7:2];
    localparam logic [5:0] C_IDX_SNAP   = C_OFF_SNAP_BASE[7:2];

    logic [AXI_ADDR_WIDTH-1:0] w_acc_waddr;
    logic [31:0]               w_acc_wdata;
    logic [3:0]                w_acc_wstrb;
    logic                      w_acc_wvalid;
    logic [AXI_ADDR_WIDTH-1:0] w_acc_raddr;
    logic [31:0]               w_acc_rdata;

    logic [C_CTRL_W-1:0]       ctrl_q, ctrl_d;
    logic [NUM_CHANNELS-1:0]   ovf_q, ovf_d;
    logic [NUM_CHANNELS-1:0]   irq_en_q, irq_en_d;
    logic                      irq_q;

    logic [31:0]               w_wmask;
    logic [5:0]                w_wr_idx;
    logic [5:0]                w_rd_idx;
    logic [NUM_CHANNELS-1:0]   w_ovf_pulse;
    logic [COUNTER_WIDTH-1:0]  w_cnt  [NUM_CHANNELS];
    logic [COUNTER_WIDTH-1:0]  w_snap [NUM_CHANNELS];
    logic                      w_unused;

    axi4l_sif #(
        .ADDR_WIDTH (AXI_ADDR_WIDTH)
    ) u_sif (
        .clk         (clk),
        .srstn       (srstn),
        .s_axi       (s_axi_ctl),
        .acc__waddr  (w_acc_waddr),
        .acc__wdata  (w_acc_wdata),
        .acc__wstrb  (w_acc_wstrb),
        .acc__wvalid (w_acc_wvalid),
        .acc__wready (1'b1),
        .acc__raddr  (w_acc_raddr),
        .acc__rready (1'b1),
        .acc__rdata  (w_acc_rdata)
    );

    assign w_wmask  = strb_to_mask(w_acc_wstrb);
    assign w_wr_idx = w_acc_waddr[7:2];
    assign w_rd_idx = w_acc_raddr[7:2];
    assign w_unused = &{1'b0, w_acc_waddr, w_acc_raddr, w_acc_wdata, w_wmask};

    generate
        for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
            event_counter_channel #(
                .COUNTER_WIDTH (COUNTER_WIDTH)
            ) u_ch (
                .clk         (clk),
                .srstn       (srstn),
                .enable_i    (enable),
                .probe_i     (probe[i]),
                .inc_en_i    (ctrl_q[C_CTRL_RUN] & enable),
                .edge_mode_i (ctrl_q[C_CTRL_EDGE]),
                .saturate_i  (ctrl_q[C_CTRL_SAT]),
                .clear_i     (ctrl_q[C_CTRL_CLEAR]),
                .snap_i      (ctrl_q[C_CTRL_SNAP]),
                .cnt_o       (w_cnt[i]),
                .snap_o      (w_snap[i]),
                .ovf_o       (w_ovf_pulse[i])
            );
        end
    endgenerate

    // Register-file next state: byte-masked writes, W1C on OVF with set priority
    always_comb begin
        ctrl_d   = {2'b00, ctrl_q[C_CTRL_SAT:C_CTRL_RUN]};
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        if (w_acc_wvalid && w_wr_idx == C_IDX_CTRL) begin
            ctrl_d = (ctrl_d & ~w_wmask[C_CTRL_W-1:0])
                   | (w_acc_wdata[C_CTRL_W-1:0] & w_wmask[C_CTRL_W-1:0]);
        end
        if (w_acc_wvalid && w_wr_idx == C_IDX_IRQ_EN) begin
            irq_en_d = (irq_en_q & ~w_wmask[NUM_CHANNELS-1:0])
                     | (w_acc_wdata[NUM_CHANNELS-1:0] & w_wmask[NUM_CHANNELS-1:0]);
        end
        if (w_acc_wvalid && w_wr_idx == C_IDX_OVF) begin
            ovf_d = ovf_q & ~(w_acc_wdata[NUM_CHANNELS-1:0] & w_wmask[NUM_CHANNELS-1:0]);
        end
        ovf_d = ovf_d | w_ovf_pulse;
        if (!enable) begin
            ovf_d = '0;
        end
    end

    // Register file and interrupt flop
    always_ff @(posedge clk) begin
        if (!srstn) begin
            ctrl_q   <= '0;
            ovf_q    <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            irq_q    <= |(ovf_q & irq_en_q);
        end
    end

    assign irq = irq_q;

    // Read mux; command bits always read back as 0
    always_comb begin
        w_acc_rdata = '0;
        if (w_rd_idx == C_IDX_CTRL) begin
            w_acc_rdata = 32'(ctrl_q[C_CTRL_SAT:C_CTRL_RUN]);
        end else if (w_rd_idx == C_IDX_OVF) begin
            w_acc_rdata = 32'(ovf_q);
        end else if (w_rd_idx == C_IDX_IRQ_EN) begin
            w_acc_rdata = 32'(irq_en_q);
        end else if (w_rd_idx == C_IDX_INFO) begin
            w_acc_rdata = {16'h0000, 8'(COUNTER_WIDTH), 8'(NUM_CHANNELS)};
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_rd_idx == C_IDX_CNT + 6'(i)) begin
                w_acc_rdata = 32'(w_cnt[i]);
            end
            if (w_rd_idx == C_IDX_SNAP + 6'(i)) begin
                w_acc_rdata = 32'(w_snap[i]);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_multi_event_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_event_counter
// Description : Scoreboard bench for two counters (32-bit and 8-bit channels)
//               sharing probe/enable and receiving identical register writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_event_counter;
    import multi_event_counter_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic       clk    = 1'b0;
    logic       srstn  = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] probe  = '0;
    logic       irq0;
    logic       irq1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m_e;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    multi_event_counter_if #(.ADDR_WIDTH(32)) if0 ();
    multi_event_counter_if #(.ADDR_WIDTH(32)) if1 ();

    multi_event_counter #(
        .AXI_ADDR_WIDTH (32),
        .NUM_CHANNELS   (4),
        .COUNTER_WIDTH  (32)
    ) dut0 (
        .clk       (clk),
        .srstn     (srstn),
        .enable    (enable),
        .s_axi_ctl (if0),
        .probe     (probe),
        .irq       (irq0)
    );

    multi_event_counter #(
        .AXI_ADDR_WIDTH (32),
        .NUM_CHANNELS   (4),
        .COUNTER_WIDTH  (8)
    ) dut1 (
        .clk       (clk),
        .srstn     (srstn),
        .enable    (enable),
        .s_axi_ctl (if1),
        .probe     (probe),
        .irq       (irq1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Broadcast register write to both DUTs
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int t;
        t = 0;
        if0.awaddr = addr; if0.wdata = data; if0.wstrb = strb;
        if1.awaddr = addr; if1.wdata = data; if1.wstrb = strb;
        if0.awvalid = 1'b1; if0.wvalid = 1'b1;
        if1.awvalid = 1'b1; if1.wvalid = 1'b1;
        #1;
        while (!(if0.awready && if1.awready) && t < 20) begin
            tick(1);
            t++;
        end
        if (t >= 20) begin
            n_run++;
            n_fail++;
            $display("FAIL wr_timeout addr 0x%08h: awready never seen, required 1", addr);
        end
        @(posedge clk);
        #1;
        if0.awvalid = 1'b0; if0.wvalid = 1'b0;
        if1.awvalid = 1'b0; if1.wvalid = 1'b0;
        tick(1);
    endtask

    // Read from one DUT; the expected value goes to that DUT's scoreboard
    task automatic rd(input int sel, input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        int   t;
        e.name = name;
        e.exp  = exp;
        t      = 0;
        if (sel == 0) begin
            q0.push_back(e);
            if0.araddr = addr; if0.arvalid = 1'b1;
        end else begin
            q1.push_back(e);
            if1.araddr = addr; if1.arvalid = 1'b1;
        end
        #1;
        while (!((sel == 0) ? if0.arready : if1.arready) && t < 20) begin
            tick(1);
            t++;
        end
        if (t >= 20) begin
            n_run++;
            n_fail++;
            $display("FAIL rd_timeout %s: arready never seen, required 1", name);
        end
        @(posedge clk);
        #1;
        if0.arvalid = 1'b0;
        if1.arvalid = 1'b0;
        tick(1);
    endtask

    // Monitor: compare each read response against the scoreboard head
    always @(negedge clk) begin
        if (if0.rvalid && if0.rready) begin
            if (q0.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL dut0_unexpected_rsp: got 0x%08h, required no response", if0.rdata);
            end else begin
                m_e = q0.pop_front();
                check(m_e.name, if0.rdata, m_e.exp);
            end
        end
        if (if1.rvalid && if1.rready) begin
            if (q1.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL dut1_unexpected_rsp: got 0x%08h, required no response", if1.rdata);
            end else begin
                m_e = q1.pop_front();
                check(m_e.name, if1.rdata, m_e.exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a_cnt, a_snap;
        a_cnt  = 32'(C_OFF_CNT_BASE);
        a_snap = 32'(C_OFF_SNAP_BASE);

        if0.awaddr = '0; if0.awvalid = 0; if0.wdata = '0; if0.wstrb = '0; if0.wvalid = 0;
        if0.araddr = '0; if0.arvalid = 0; if0.bready = 1; if0.rready = 1;
        if1.awaddr = '0; if1.awvalid = 0; if1.wdata = '0; if1.wstrb = '0; if1.wvalid = 0;
        if1.araddr = '0; if1.arvalid = 0; if1.bready = 1; if1.rready = 1;

        enable = 1'b1;
        tick(3);
        srstn = 1'b1;
        tick(1);

        // Reset values and INFO
        check("rst_irq0", {31'b0, irq0}, 32'h0);
        rd(0, 32'h00, 32'h0, "rst_ctrl");
        rd(0, 32'h04, 32'h0, "rst_ovf");
        rd(0, 32'h08, 32'h0, "rst_irq_en");
        rd(0, a_cnt,  32'h0, "rst_cnt0");
        rd(0, a_snap, 32'h0, "rst_snap0");
        rd(0, 32'h0C, 32'h0000_2004, "info_dut0");
        rd(1, 32'h0C, 32'h0000_0804, "info_dut1");
        rd(0, 32'h10, 32'h0, "unmapped_read");

        // Level mode: 10 high cycles
        wr(32'h00, 32'h1, 4'hF);
        probe[0] = 1'b1; tick(10); probe[0] = 1'b0;
        rd(0, a_cnt,     32'd10, "level_cnt0");
        rd(1, a_cnt,     32'd10, "level_cnt0_w8");
        rd(0, a_cnt + 4, 32'd0,  "level_cnt1_idle");

        // Edge mode: 3 pulses of 4 cycles
        wr(32'h00, 32'h0B, 4'hF);
        for (int p = 0; p < 3; p++) begin
            probe[0] = 1'b1; tick(4);
            probe[0] = 1'b0; tick(4);
        end
        rd(0, a_cnt, 32'd3, "edge_cnt0");
        rd(0, 32'h00, 32'h3, "ctrl_clear_reads0");

        // Wrap: 257 events on the 8-bit counter
        wr(32'h00, 32'h09, 4'hF);
        probe[0] = 1'b1; tick(257); probe[0] = 1'b0;
        rd(1, a_cnt,  32'd1,   "wrap_cnt0_w8");
        rd(1, 32'h04, 32'h1,   "wrap_ovf_w8");
        rd(0, a_cnt,  32'd257, "wrap_cnt0_w32");
        rd(0, 32'h04, 32'h0,   "wrap_ovf_w32");

        // Saturate: 257 events, counter pins at 0xFF
        wr(32'h04, 32'h1, 4'hF);
        rd(1, 32'h04, 32'h0, "w1c_ovf_w8");
        wr(32'h00, 32'h0D, 4'hF);
        probe[0] = 1'b1; tick(257); probe[0] = 1'b0;
        rd(1, a_cnt,  32'hFF, "sat_cnt0_w8");
        rd(1, 32'h04, 32'h1,  "sat_ovf_w8");

        // Snapshot with channels at different rates
        wr(32'h00, 32'h09, 4'hF);
        for (int i = 0; i < 12; i++) begin
            probe = {1'b0, (i % 4 == 0), (i % 2 == 0), 1'b1};
            tick(1);
        end
        probe = '0;
        wr(32'h00, 32'h11, 4'hF);
        rd(0, a_snap,      32'd12, "snap0");
        rd(0, a_snap + 4,  32'd6,  "snap1");
        rd(0, a_snap + 8,  32'd3,  "snap2");
        rd(0, a_snap + 12, 32'd0,  "snap3");
        probe[0] = 1'b1; tick(5); probe[0] = 1'b0;
        rd(0, a_cnt,  32'd17, "cnt0_after_snap");
        rd(0, a_snap, 32'd12, "snap0_held");

        // Clear with probe high: clear wins, snapshots untouched
        probe[0] = 1'b1;
        wr(32'h00, 32'h09, 4'hF);
        probe[0] = 1'b0;
        rd(0, a_cnt,      32'd0,  "clear_cnt0");
        rd(0, a_cnt + 4,  32'd0,  "clear_cnt1");
        rd(0, a_snap,     32'd12, "clear_snap0");
        rd(0, a_snap + 4, 32'd6,  "clear_snap1");

        // IRQ: overflow channel 0 of the 8-bit counter
        wr(32'h04, 32'hF, 4'hF);
        wr(32'h08, 32'h1, 4'hF);
        check("irq1_idle", {31'b0, irq1}, 32'h0);
        wr(32'h00, 32'h09, 4'hF);
        probe[0] = 1'b1; tick(256); probe[0] = 1'b0;
        check("irq1_lag", {31'b0, irq1}, 32'h0);
        tick(1);
        check("irq1_set", {31'b0, irq1}, 32'h1);
        check("irq0_quiet", {31'b0, irq0}, 32'h0);
        wr(32'h04, 32'h1, 4'hF);
        check("irq1_after_w1c", {31'b0, irq1}, 32'h0);
        rd(1, 32'h04, 32'h0, "ovf_after_w1c");

        // W1C coincident with a new overflow: set wins
        wr(32'h00, 32'h0F, 4'hF);
        for (int p = 0; p < 255; p++) begin
            probe[0] = 1'b1; tick(1);
            probe[0] = 1'b0; tick(1);
        end
        rd(1, 32'h04, 32'h0,  "allones_no_ovf");
        rd(1, a_cnt,  32'hFF, "allones_cnt");
        probe[0] = 1'b1;
        wr(32'h04, 32'h1, 4'hF);
        probe[0] = 1'b0;
        rd(1, 32'h04, 32'h1,  "w1c_vs_set");
        rd(1, a_cnt,  32'hFF, "w1c_vs_set_cnt");

        // enable low for one cycle
        enable = 1'b0; tick(1); enable = 1'b1;
        tick(1);
        rd(1, a_cnt,  32'h0, "en_drop_cnt0");
        rd(1, a_snap, 32'h0, "en_drop_snap0");
        rd(1, 32'h04, 32'h0, "en_drop_ovf");
        rd(1, 32'h00, 32'h7, "en_drop_ctrl");
        rd(1, 32'h08, 32'h1, "en_drop_irq_en");
        check("en_drop_irq1", {31'b0, irq1}, 32'h0);
        for (int p = 0; p < 2; p++) begin
            probe[0] = 1'b1; tick(1);
            probe[0] = 1'b0; tick(1);
        end
        rd(1, a_cnt, 32'd2, "en_resume_cnt0");

        // Byte strobes and read-only writes
        wr(32'h00, 32'h0, 4'b1110);
        rd(1, 32'h00, 32'h7, "strb_ctrl_kept");
        wr(32'h0C, 32'hFFFF_FFFF, 4'hF);
        rd(0, 32'h0C, 32'h0000_2004, "info_ro");

        tick(3);
        while (q0.size() > 0) begin
            m_e = q0.pop_front();
            n_run++; n_fail++;
            $display("FAIL %s: no read response, required 0x%08h", m_e.name, m_e.exp);
        end
        while (q1.size() > 0) begin
            m_e = q1.pop_front();
            n_run++; n_fail++;
            $display("FAIL %s: no read response, required 0x%08h", m_e.name, m_e.exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multi_event_counter.md
# multi_event_counter

Parametrised multi-channel event counter with an AXI4-Lite control/status slave. Counts up to `num_channels` synchronous probe inputs, each in level (cycles-high) or edge (rising-edge) mode, with wrap or saturate, per-channel overflow flags, atomic snapshot and a level interrupt. Sits beside the datapath as a debug/performance monitor; the AXI front-end is the team's `axi4l_sif`.

## Interface
- `axi_addr_width`, 32, AXI address width.
- `num_channels`, 4, probe channels; 1..16.
- `counter_width`, 32, counter bits per channel; 1..32, zero-extended to 32 on read.
- `clk`  in  1  clock.
- `srstn`  in  1  reset, synchronous, active-low.
- `enable`  in  1  global enable; low clears counters, snapshots, edge history and OVF; register settings are kept.
- `s_axi_ctl_*`  AXI4-Lite slave (aw/w/b/ar/r, 32-bit data, `axi_addr_width` address), passed to `axi4l_sif`.
- `probe`  in  `num_channels`  event inputs, synchronous to `clk`.
- `irq`  out  1  registered, `|(OVF & IRQ_EN)`.

## Operation
- Register map, byte offsets, decoded on `addr[7:2]`:
  - 0x00 CTRL RW: [0] run, [1] edge_mode, [2] saturate, [3] clear (W1, self-clearing, reads 0), [4] snap (W1, self-clearing, reads 0).
  - 0x04 OVF RW1C: bit i = channel i overflowed.
  - 0x08 IRQ_EN RW: bit i enables channel i into `irq`.
  - 0x0C INFO RO: [7:0] num_channels, [15:8] counter_width.
  - 0x40+4i CNT[i] RO: live count. 0x80+4i SNAP[i] RO: snapshot.
- Writes: `wstrb` honoured per byte on RW registers; writes to RO or unmapped offsets are ignored. Reads of unmapped offsets return 0. `acc__wready` and `acc__rready` are tied 1. `acc__rdata` is combinational from `acc__raddr`.
- Increment condition for channel i: `run & enable & (edge_mode ? probe[i] & ~prev[i] : probe[i])`. `prev` is registered every cycle and reset to 0.
- Overflow: an increment at all-ones sets OVF[i]. The counter goes to 0 when saturate=0 and holds at all-ones when saturate=1.
- clear: zeroes all CNT in the cycle after the write. It does not touch OVF or SNAP.
- snap: copies every CNT[i] into SNAP[i] in the same cycle, atomically across channels.
- Reset values (srstn low): CTRL=0, OVF=0, IRQ_EN=0, CNT=0, SNAP=0, prev=0, irq=0. AXI outputs follow `axi4l_sif` reset.

## Timing
- Probe sampled at edge N: CNT is visible at edge N+1. In edge mode a rising edge sampled at N counts at N+1.
- Register write accepted at edge N (`acc__wvalid`): takes effect at N+1. clear/snap act at N+1, and their bits read 0 thereafter.
- Simultaneous events:
  - clear and increment in the same cycle: clear wins, CNT=0.
  - snap and increment in the same cycle: SNAP gets the pre-increment value.
  - OVF W1C and a new overflow on the same bit: set wins.
- `irq` lags the OVF/IRQ_EN change by one cycle.
- srstn or enable low mid-count: the effect is synchronous, at the next edge. No partial increments are retained.
- Width: counter arithmetic is modulo 2^counter_width. Read data [31:counter_width] = 0.

## Structure
- Package `multi_event_counter_pkg`: register offset constants (CTRL, OVF, IRQ_EN, INFO, CNT_BASE, SNAP_BASE) and CTRL bit indices.
- Sub-module `event_counter_channel`: one instance per channel, generated. It holds prev, CNT, SNAP and the overflow pulse, with inputs inc_en, edge_mode, saturate, clear, snap.
- Top: `axi4l_sif` instance, register file, read mux, OVF/IRQ logic.

## Test plan
- Reset/INFO: after srstn, read all registers -> 0. INFO reads 0x00002004 for defaults.
- Level vs edge: run=1, hold probe[0] high 10 cycles -> CNT[0]=10. Repeat with edge_mode=1 and 3 pulses of 4 cycles each -> CNT[0]=3.
- Wrap/saturate with counter_width=8: 257 events, saturate=0 -> CNT=1 and OVF[0]=1. Same with saturate=1 -> CNT=0xFF and OVF[0]=1.
- Snapshot/clear: channels counting at different rates. Write snap -> all SNAP equal CNT at that edge, and CNT keeps counting. Write clear with probe high -> CNT=0 that cycle, and SNAP is unchanged.
- IRQ/W1C: IRQ_EN=0x1, overflow ch0 -> irq=1 one cycle after OVF. Write OVF=0x1 -> irq=0. W1C coincident with a new overflow -> OVF stays 1.
- enable drop mid-count: enable=0 for 1 cycle -> CNT, SNAP and OVF become 0. CTRL and IRQ_EN are retained, and counting resumes.
